// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the vblank arbiter state encoding.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int HD   = 640;
  localparam int HFP  = 16;
  localparam int HSW  = 96;
  localparam int HBP  = 48;
  localparam int HTOT = 800;

  // Vertical timing, in lines
  localparam int VD   = 480;
  localparam int VFP  = 10;
  localparam int VSW  = 2;
  localparam int VBP  = 33;
  localparam int VTOT = 525;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    G_USR = 2'd2,
    G_RTC = 2'd3
  } arb_state_t;

endpackage

// File: rtl/blink_div.sv
// Divides frame ticks into a cursor blink square wave of BLINK_FRAMES ticks per half-period.
// Latency: blink toggles 1 clk after the qualifying tick.
// Backpressure: none, tick is consumed every cycle it is high.
module blink_div #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic blink
);

  localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] cnt;

  // Count ticks; on the last tick of a half-period wrap to zero and flip blink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (tick) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vblank_arbiter.sv
// Shares the display register bank between RTC read-back and user edit, only during vblank.
// Latency: window/frame_tick 1 clk after px_y reaches VD; grant 1 clk after a qualifying request in OPEN.
// Backpressure: requests are levels held until granted; a grant is held until done or window close (abort).
module vblank_arbiter #(
  parameter int VD           = vga_timing_pkg::VD,
  parameter int VTOT         = vga_timing_pkg::VTOT,
  parameter int MIN_LINES    = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_pix,
  input  logic [9:0] px_y,
  input  logic       req_usr,
  input  logic       req_rtc,
  input  logic       done_usr,
  input  logic       done_rtc,
  output logic       gnt_usr,
  output logic       gnt_rtc,
  output logic       abort,
  output logic       window,
  output logic       frame_tick,
  output logic       blink
);

  import vga_timing_pkg::*;

  localparam logic [10:0] VD_L   = 11'(VD);
  localparam logic [10:0] VTOT_L = 11'(VTOT);
  localparam logic [10:0] MIN_L  = 11'(MIN_LINES);

  arb_state_t  state;
  logic [10:0] py;
  logic        vb;
  logic        win_rise;
  logic        win_fall;
  logic        lines_ok;
  logic        elig_usr;
  logic        elig_rtc;
  logic        contend;
  logic        pick_usr;
  logic        pick_rtc;
  logic        used_usr;
  logic        used_rtc;
  logic        rr;
  logic        unused_en_pix;

  // px_y is stable between pixel enables, so sampling blanking every clock is equivalent.
  assign unused_en_pix = en_pix;

  assign py       = {1'b0, px_y};
  assign vb       = (py >= VD_L);
  assign win_rise = vb & ~window;
  assign win_fall = window & ~vb;

  // Lines beyond VTOT still count as blanking but never leave room for a new grant.
  assign lines_ok = (py < VTOT_L) && ((VTOT_L - py) >= MIN_L);

  assign elig_usr = req_usr & ~used_usr & lines_ok;
  assign elig_rtc = req_rtc & ~used_rtc & lines_ok;
  assign contend  = elig_usr & elig_rtc;

  // rr=0 favours user, rr=1 favours RTC; it only decides real contention.
  assign pick_usr = elig_usr & (~elig_rtc | ~rr);
  assign pick_rtc = elig_rtc & (~elig_usr |  rr);

  // Register blanking into the window and flag its rising edge as the frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      window     <= vb;
      frame_tick <= win_rise;
    end
  end

  // Arbiter FSM: one owner at a time, one grant per requester per window, abort on overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_usr  <= 1'b0;
      gnt_rtc  <= 1'b0;
      abort    <= 1'b0;
      rr       <= 1'b0;
      used_usr <= 1'b0;
      used_rtc <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (win_rise) begin
        used_usr <= 1'b0;
        used_rtc <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (win_rise) state <= OPEN;
        end
        OPEN: begin
          if (win_fall) begin
            state <= IDLE;
          end else if (pick_usr) begin
            state    <= G_USR;
            gnt_usr  <= 1'b1;
            used_usr <= 1'b1;
            if (contend) rr <= 1'b1;
          end else if (pick_rtc) begin
            state    <= G_RTC;
            gnt_rtc  <= 1'b1;
            used_rtc <= 1'b1;
            if (contend) rr <= 1'b0;
          end
        end
        G_USR: begin
          if (done_usr || win_fall) begin
            state   <= win_fall ? IDLE : OPEN;
            gnt_usr <= 1'b0;
            // An overrun user goes first at the next contention.
            if (!done_usr) begin
              abort <= 1'b1;
              rr    <= 1'b0;
            end
          end
        end
        G_RTC: begin
          if (done_rtc || win_fall) begin
            state   <= win_fall ? IDLE : OPEN;
            gnt_rtc <= 1'b0;
            // An overrun RTC goes first at the next contention.
            if (!done_rtc) begin
              abort <= 1'b1;
              rr    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          gnt_usr <= 1'b0;
          gnt_rtc <= 1'b0;
        end
      endcase
    end
  end

  blink_div #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick),
    .blink(blink)
  );

endmodule

// File: tb/tb_vblank_arbiter.sv
// Scoreboard bench for vblank_arbiter: randomized and directed frames against a frame-level model.
// Latency: expectations are produced at each posedge and compared at the following negedge.
// Backpressure: none, the monitor consumes one expectation per cycle.
module tb_vblank_arbiter;

  localparam int VD        = 480;
  localparam int VTOT      = 525;
  localparam int MIN_LINES = 4;
  localparam int BF        = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_pix = 1'b0;
  logic [9:0] px_y = '0;
  logic       req_usr = 1'b0;
  logic       req_rtc = 1'b0;
  logic       done_usr = 1'b0;
  logic       done_rtc = 1'b0;
  logic       gnt_usr, gnt_rtc, abort, window, frame_tick, blink;

  vblank_arbiter #(
    .VD(VD), .VTOT(VTOT), .MIN_LINES(MIN_LINES), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .en_pix(en_pix), .px_y(px_y),
    .req_usr(req_usr), .req_rtc(req_rtc), .done_usr(done_usr), .done_rtc(done_rtc),
    .gnt_usr(gnt_usr), .gnt_rtc(gnt_rtc), .abort(abort), .window(window),
    .frame_tick(frame_tick), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic gu; logic gr; logic ab; logic win; logic tick; logic blink;
  } ov_t;

  ov_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (owner / per-frame bookkeeping) ----------------
  int m_owner;      // 0 nobody, 1 user, 2 RTC
  bit m_win, m_used_u, m_used_r, m_fav_rtc, m_tick, m_abort;
  int m_ticks;

  task automatic model_reset();
    m_owner = 0; m_win = 0; m_used_u = 0; m_used_r = 0;
    m_fav_rtc = 0; m_tick = 0; m_abort = 0; m_ticks = 0;
  endtask

  task automatic model_step();
    int py, who;
    bit vb, rise, fall, was_open, ok, eu, er;
    py       = int'(px_y);
    vb       = (py >= VD);
    rise     = vb && !m_win;
    fall     = m_win && !vb;
    was_open = m_win && (m_owner == 0);
    if (m_tick) m_ticks++;
    m_tick  = rise;
    m_abort = 0;
    if (rise) begin m_used_u = 0; m_used_r = 0; end
    if (m_owner == 1) begin
      if (done_usr) m_owner = 0;
      else if (fall) begin m_owner = 0; m_abort = 1; m_fav_rtc = 0; end
    end else if (m_owner == 2) begin
      if (done_rtc) m_owner = 0;
      else if (fall) begin m_owner = 0; m_abort = 1; m_fav_rtc = 1; end
    end else if (was_open && !fall) begin
      ok  = (py < VTOT) && ((VTOT - py) >= MIN_LINES);
      eu  = req_usr && !m_used_u && ok;
      er  = req_rtc && !m_used_r && ok;
      who = 0;
      if (eu && er) begin who = m_fav_rtc ? 2 : 1; m_fav_rtc = (who == 1); end
      else if (eu) who = 1;
      else if (er) who = 2;
      if (who == 1) m_used_u = 1;
      if (who == 2) m_used_r = 1;
      m_owner = who;
    end
    m_win = vb;
  endtask

  initial begin
    ov_t e;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      e.gu = (m_owner == 1); e.gr = (m_owner == 2); e.ab = m_abort;
      e.win = m_win; e.tick = m_tick; e.blink = (((m_ticks / BF) % 2) == 1);
      sb.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  int   n_ticks = 0, n_aborts = 0, n_bedges = 0, abort_line = -1;
  int   glog_who[$];
  int   glog_line[$];
  logic prev_gu = 1'b0, prev_gr = 1'b0, prev_blink = 1'b0;

  initial begin
    ov_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {gnt_usr, gnt_rtc, abort, window, frame_tick, blink};
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL scoreboard t=%0t px_y=%0d got gu/gr/ab/win/tick/blink=%b expected %b",
                     $time, px_y, a, e);
        end
      end
      if (rst) begin
        n_ticks = 0; n_bedges = 0; prev_gu = 0; prev_gr = 0; prev_blink = 0;
      end else begin
        if (gnt_usr && !prev_gu) begin glog_who.push_back(1); glog_line.push_back(int'(px_y)); end
        if (gnt_rtc && !prev_gr) begin glog_who.push_back(2); glog_line.push_back(int'(px_y)); end
        if (frame_tick) n_ticks++;
        if (abort) begin n_aborts++; abort_line = int'(px_y); end
        if (blink !== prev_blink) begin
          n_bedges++;
          check("blink_period", n_ticks, BF * n_bedges);
        end
        prev_gu = gnt_usr; prev_gr = gnt_rtc; prev_blink = blink;
      end
    end
  end

  // ---------------- stimulus ----------------
  int mode;          // 0 fixed requests, 1 late user request, 2 random
  bit fix_u, fix_r, late, wrapped;
  int dly_u, dly_r, hu, hr, py_i, frame_last;

  function automatic int pick_dly();
    if ($urandom_range(0, 9) == 0) return 0;
    return int'($urandom_range(1, 6));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    done_usr = 1'b0;
    done_rtc = 1'b0;
    if (gnt_usr) begin
      hu++;
      if (mode == 2 && hu == 1) dly_u = pick_dly();
      if (dly_u != 0 && hu == dly_u) done_usr = 1'b1;
    end else begin
      hu = 0;
      if (mode == 2 && $urandom_range(0, 49) == 0) done_usr = 1'b1;
    end
    if (gnt_rtc) begin
      hr++;
      if (mode == 2 && hr == 1) dly_r = pick_dly();
      if (dly_r != 0 && hr == dly_r) done_rtc = 1'b1;
    end else begin
      hr = 0;
      if (mode == 2 && $urandom_range(0, 49) == 0) done_rtc = 1'b1;
    end
    en_pix = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (en_pix) begin
      if (py_i >= frame_last) begin
        py_i = 0;
        wrapped = 1;
        frame_last = VTOT - 1;
        if (mode == 2 && $urandom_range(0, 3) == 0) frame_last = VTOT - 1 + int'($urandom_range(1, 6));
      end else begin
        py_i++;
      end
      px_y = 10'(py_i);
    end
    case (mode)
      0: begin req_usr = fix_u; req_rtc = fix_r; end
      1: begin
        if (py_i >= 522) late = 1;
        req_usr = late;
        req_rtc = 1'b0;
      end
      default: begin
        if ($urandom_range(0, 39) == 0) req_usr = ~req_usr;
        if ($urandom_range(0, 39) == 0) req_rtc = ~req_rtc;
      end
    endcase
  endtask

  task automatic run_frame();
    wrapped = 0;
    while (!wrapped) cycle();
  endtask

  initial begin
    int exp_order[6];
    int exp_abort[3];
    int a0, t0;
    bit seen;
    exp_order = '{1, 2, 2, 1, 1, 2};
    exp_abort = '{2, 2, 1};
    mode = 0; fix_u = 0; fix_r = 0; late = 0; wrapped = 0;
    dly_u = 1; dly_r = 1; hu = 0; hr = 0; py_i = 0; frame_last = VTOT - 1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt_usr", int'(gnt_usr), 0);
    check("rst_gnt_rtc", int'(gnt_rtc), 0);
    check("rst_abort", int'(abort), 0);
    check("rst_window", int'(window), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    check("rst_blink", int'(blink), 0);
    rst = 1'b0;

    // Single RTC requester over one frame
    fix_r = 1; dly_r = 1;
    t0 = n_ticks;
    run_frame();
    check("p1_ticks", n_ticks - t0, 1);
    check("p1_grants", glog_who.size(), 1);
    check("p1_who", (glog_who.size() > 0) ? glog_who[0] : -1, 2);
    check("p1_grant_line", (glog_line.size() > 0) ? glog_line[0] : -1, 482);

    // Contention over three frames, done two clocks into each grant
    glog_who.delete(); glog_line.delete();
    fix_u = 1; fix_r = 1; dly_u = 2; dly_r = 2;
    repeat (3) run_frame();
    check("p2_grants", glog_who.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("p2_order%0d", i), (glog_who.size() > i) ? glog_who[i] : -1, exp_order[i]);

    // RTC overruns the window, then wins the next contention
    glog_who.delete(); glog_line.delete();
    a0 = n_aborts;
    dly_u = 0; dly_r = 0;
    run_frame();
    dly_u = 2; dly_r = 2;
    run_frame();
    check("p3_aborts", n_aborts - a0, 1);
    check("p3_abort_line", abort_line, 1);
    check("p3_grants", glog_who.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("p3_order%0d", i), (glog_who.size() > i) ? glog_who[i] : -1, exp_abort[i]);

    // User request arriving with only three blanking lines left
    glog_who.delete(); glog_line.delete();
    fix_u = 0; fix_r = 0; mode = 1; late = 0; dly_u = 1;
    run_frame();
    check("p4_no_late_grant", glog_who.size(), 0);
    run_frame();
    check("p4_grants", glog_who.size(), 1);
    check("p4_who", (glog_who.size() > 0) ? glog_who[0] : -1, 1);
    check("p4_grant_line", (glog_line.size() > 0) ? glog_line[0] : -1, 482);

    // Randomized traffic, sparse pixel enables, stray dones, over-long frames
    mode = 2;
    repeat (8) run_frame();
    mode = 0; fix_u = 0; fix_r = 0;
    run_frame();
    check("blink_edges", n_bedges, n_ticks / BF);

    // Reset asserted while the user holds the bank
    fix_u = 1; dly_u = 0;
    seen = 0;
    for (int i = 0; i < 4 * VTOT && !seen; i++) begin
      cycle();
      seen = gnt_usr;
    end
    check("p6_gnt_seen", int'(seen), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("p6_gnt_usr", int'(gnt_usr), 0);
    check("p6_abort", int'(abort), 0);
    check("p6_window", int'(window), 0);
    check("p6_blink", int'(blink), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fix_u = 0;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
